// File: rtl/sd_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_phy_pkg
// Purpose  : Shared encodings and frame lengths for the SD CMD-line PHY.
// Revision : 1.0 - initial release
// ============================================================================
package sd_phy_pkg;

    localparam logic [1:0] RESP_NONE      = 2'd0;
    localparam logic [1:0] RESP_R48       = 2'd1;
    localparam logic [1:0] RESP_R136      = 2'd2;
    localparam logic [1:0] RESP_R48_NOCRC = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TX   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_RX   = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam int CMD_FRAME_LEN = 48;
    localparam int R2_FRAME_LEN  = 136;

endpackage
`default_nettype wire

// File: rtl/sd_phy_cmd_crc_7.sv
`default_nettype none
// ============================================================================
// Module   : sd_phy_cmd_crc_7
// Purpose  : Serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
// Revision : 1.0 - initial release
// ============================================================================
module sd_phy_cmd_crc_7 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [6:0] crc
);

    logic [6:0] r_crc;
    logic       w_feedback;

    assign w_feedback = r_crc[6] ^ data_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc <= '0;
        end else if (clear) begin
            r_crc <= '0;
        end else if (enable) begin
            r_crc <= {r_crc[5:3], r_crc[2] ^ w_feedback, r_crc[1:0], w_feedback};
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_phy_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_phy_cmd_ctrl
// Purpose  : Sequences one SD CMD-line transaction: command out, response in.
// Revision : 1.0 - initial release
// ============================================================================
module sd_phy_cmd_ctrl
    import sd_phy_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_en,
    input  logic         start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic         crc_err,
    output logic [127:0] resp,
    output logic         cmd_out,
    output logic         cmd_oe,
    input  logic         cmd_in
);

    localparam int         c_WAIT_W       = $clog2(RESP_TIMEOUT + 1);
    localparam logic [7:0] c_TX_CRC_BIT   = 8'd40;
    localparam logic [7:0] c_TX_END       = 8'(CMD_FRAME_LEN);
    localparam logic [7:0] c_R48_CRC_LAST = 8'd39;
    localparam logic [7:0] c_R2_CRC_FIRST = 8'd8;
    localparam logic [7:0] c_R2_CRC_LAST  = 8'd127;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [7:0]          r_bit_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_inc;
    logic [39:0]         r_tx_shift;
    logic [1:0]          r_resp_type;
    logic [126:0]        r_rx_shift;
    logic [127:0]        w_rx_shift_next;
    logic [127:0]        r_resp;
    logic                r_timeout;
    logic                r_crc_err;
    logic                r_cmd_out;
    logic                r_cmd_oe;
    logic                w_tx_last;
    logic                w_wait_expire;
    logic [7:0]          w_rx_last_bit;
    logic                w_rx_crc_window;
    logic                w_crc_check;
    logic                w_crc_clear;
    logic                w_crc_enable;
    logic                w_crc_data;
    logic [6:0]          w_crc;

    assign w_tx_last       = bit_en && (r_bit_cnt == c_TX_END);
    assign w_wait_inc      = r_wait_cnt + 1'b1;
    assign w_wait_expire   = (w_wait_inc == c_WAIT_W'(RESP_TIMEOUT));
    assign w_rx_last_bit   = (r_resp_type == RESP_R136) ? 8'(R2_FRAME_LEN - 1) : 8'(CMD_FRAME_LEN - 1);
    assign w_rx_shift_next = {r_rx_shift, cmd_in};
    assign w_crc_check     = (r_resp_type == RESP_R48) || (r_resp_type == RESP_R136);

    // The start bit is never fed: a zero into a cleared CRC7 leaves it zero.
    assign w_rx_crc_window = (r_resp_type == RESP_R136)
                           ? ((r_bit_cnt >= c_R2_CRC_FIRST) && (r_bit_cnt <= c_R2_CRC_LAST))
                           : (r_bit_cnt <= c_R48_CRC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_TX;
            ST_TX: begin
                if (w_tx_last) begin
                    w_state_next = (r_resp_type == RESP_NONE) ? ST_FIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bit_en) begin
                    if (!cmd_in) begin
                        w_state_next = ST_RX;
                    end else if (w_wait_expire) begin
                        w_state_next = ST_FIN;
                    end
                end
            end
            ST_RX: if (bit_en && (r_bit_cnt == w_rx_last_bit)) w_state_next = ST_FIN;
            ST_FIN: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_crc_clear  = 1'b0;
        w_crc_enable = 1'b0;
        w_crc_data   = cmd_in;
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_FIN);
        case (r_state)
            ST_IDLE: w_crc_clear = start;
            ST_TX: begin
                w_crc_data   = r_tx_shift[39];
                w_crc_enable = bit_en && (r_bit_cnt < c_TX_CRC_BIT);
                w_crc_clear  = w_tx_last;
            end
            ST_RX: w_crc_enable = bit_en && w_rx_crc_window;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_tx_shift  <= '0;
            r_resp_type <= RESP_NONE;
            r_rx_shift  <= '0;
            r_resp      <= '0;
            r_timeout   <= 1'b0;
            r_crc_err   <= 1'b0;
            r_cmd_out   <= 1'b1;
            r_cmd_oe    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tx_shift  <= {2'b01, cmd_index, cmd_arg};
                        r_resp_type <= resp_type;
                        r_bit_cnt   <= '0;
                        r_timeout   <= 1'b0;
                        r_crc_err   <= 1'b0;
                        r_resp      <= '0;
                    end
                end
                ST_TX: begin
                    if (bit_en) begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt == c_TX_END) begin
                            r_cmd_oe   <= 1'b0;
                            r_cmd_out  <= 1'b1;
                            r_wait_cnt <= '0;
                        end else if (r_bit_cnt == c_TX_CRC_BIT) begin
                            // CRC is final here; reload the shifter with CRC tail and end bit.
                            r_cmd_oe   <= 1'b1;
                            r_cmd_out  <= w_crc[6];
                            r_tx_shift <= {w_crc[5:0], 1'b1, 33'd0};
                        end else begin
                            r_cmd_oe   <= 1'b1;
                            r_cmd_out  <= r_tx_shift[39];
                            r_tx_shift <= {r_tx_shift[38:0], 1'b0};
                        end
                    end
                end
                ST_WAIT: begin
                    if (bit_en) begin
                        if (!cmd_in) begin
                            r_bit_cnt <= 8'd1;
                        end else begin
                            r_wait_cnt <= w_wait_inc;
                            if (w_wait_expire) r_timeout <= 1'b1;
                        end
                    end
                end
                ST_RX: begin
                    if (bit_en) begin
                        r_rx_shift <= w_rx_shift_next[126:0];
                        r_bit_cnt  <= r_bit_cnt + 8'd1;
                        if (r_bit_cnt == w_rx_last_bit) begin
                            r_resp    <= (r_resp_type == RESP_R136) ? w_rx_shift_next
                                                                     : {90'd0, w_rx_shift_next[45:8]};
                            r_crc_err <= !w_rx_shift_next[0]
                                       || (w_crc_check && (w_rx_shift_next[7:1] != w_crc));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    sd_phy_cmd_crc_7 u_crc (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_crc_clear),
        .enable   (w_crc_enable),
        .data_bit (w_crc_data),
        .crc      (w_crc)
    );

    assign timeout = r_timeout;
    assign crc_err = r_crc_err;
    assign resp    = r_resp;
    assign cmd_out = r_cmd_out;
    assign cmd_oe  = r_cmd_oe;

endmodule
`default_nettype wire

// File: tb/tb_sd_phy_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_phy_cmd_ctrl
// Purpose  : Self-checking bench: vector table, reset abort, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_phy_cmd_ctrl;

    localparam int RESP_TIMEOUT = 64;

    logic         clk;
    logic         reset;
    logic         bit_en;
    logic         start;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   resp_type;
    logic         busy;
    logic         done;
    logic         timeout;
    logic         crc_err;
    logic [127:0] resp;
    logic         cmd_out;
    logic         cmd_oe;
    logic         cmd_in;

    sd_phy_cmd_ctrl #(.RESP_TIMEOUT(RESP_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_en    (bit_en),
        .start     (start),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .resp_type (resp_type),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .crc_err   (crc_err),
        .resp      (resp),
        .cmd_out   (cmd_out),
        .cmd_oe    (cmd_oe),
        .cmd_in    (cmd_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rt;
        logic [135:0] rsp;        // response frame, frame bit 0 at position len-1
        int           gap;        // idle bit periods before the start bit
        int           poke;       // TX bit at which a stray start is pulsed, -1 = none
        logic [47:0]  exp_stream;
        logic         exp_to;
        logic         exp_ce;
        logic [127:0] exp_resp;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;
    logic         d_to, d_ce, d_busy;
    logic [127:0] d_resp;
    logic         cap_out, cap_oe, cap_to;
    vec_t         vt [10];

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, message = f[top:8].
    function automatic logic [6:0] crc7_div(input logic [135:0] f, input int top);
        logic [142:0] r;
        r = '0;
        for (int i = 8; i <= top; i++) r[i - 1] = f[i];
        for (int i = top - 1; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] tx_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] f;
        f = {88'd0, 2'b01, idx, arg, 7'd0, 1'b1};
        f[7:1] = crc7_div(f, 47);
        return f[47:0];
    endfunction

    function automatic logic [135:0] r1_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] f;
        f = {88'd0, 2'b00, idx, arg, 7'd0, 1'b1};
        f[7:1] = crc7_div(f, 47);
        return f;
    endfunction

    function automatic logic [135:0] r2_frame(input logic [119:0] payload, input logic end_bit);
        logic [135:0] f;
        f = {8'h3F, payload, 7'd0, end_bit};
        f[7:1] = crc7_div(f, 127);
        return f;
    endfunction

    function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                                input logic [135:0] rsp, input int gap, input int poke,
                                input logic [47:0] s, input logic to, input logic ce,
                                input logic [127:0] rs);
        vec_t v;
        v.idx = idx; v.arg = arg; v.rt = rt; v.rsp = rsp; v.gap = gap; v.poke = poke;
        v.exp_stream = s; v.exp_to = to; v.exp_ce = ce; v.exp_resp = rs;
        return v;
    endfunction

    // Reference model: outcome of a transaction from the frame rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t o;
        int   top;
        o = v;
        o.exp_stream = tx_frame(v.idx, v.arg);
        o.exp_to = 1'b0; o.exp_ce = 1'b0; o.exp_resp = '0;
        if (v.rt != 2'd0) begin
            if (v.gap >= RESP_TIMEOUT) begin
                o.exp_to = 1'b1;
            end else begin
                top = (v.rt == 2'd2) ? 127 : 47;
                o.exp_ce = !v.rsp[0] || ((v.rt != 2'd3) && (v.rsp[7:1] != crc7_div(v.rsp, top)));
                o.exp_resp = (v.rt == 2'd2) ? v.rsp[127:0] : {90'd0, v.rsp[45:8]};
            end
        end
        return o;
    endfunction

    task automatic clk_step(input logic be);
        bit_en = be;
        @(negedge clk);
        if (done) begin
            n_done++;
            d_to = timeout; d_ce = crc_err; d_resp = resp; d_busy = busy;
        end
    endtask

    task automatic bit_period(input logic ci);
        cmd_in = ci;
        clk_step(1'b1);
        cap_out = cmd_out; cap_oe = cmd_oe; cap_to = timeout;
        cmd_in = 1'b1;
        repeat ($urandom_range(0, 2)) clk_step(1'b0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [47:0] stream;
        logic        oe_ok;
        int          done_before, len, to_bit;
        done_before = n_done;
        oe_ok = 1'b1;
        to_bit = 0;
        cmd_index = v.idx; cmd_arg = v.arg; resp_type = v.rt; start = 1'b1;
        clk_step(1'b0);
        start = 1'b0;
        check($sformatf("%s busy_at_accept", tag), busy, 1);
        for (int n = 0; n < 48; n++) begin
            if (n == v.poke) begin
                start = 1'b1; cmd_index = ~v.idx; cmd_arg = ~v.arg; resp_type = ~v.rt;
                clk_step(1'b0);
                start = 1'b0;
            end
            bit_period(1'b1);
            stream[47 - n] = cap_out;
            oe_ok = oe_ok & cap_oe;
        end
        check($sformatf("%s stream", tag), stream, v.exp_stream);
        check($sformatf("%s oe_during_tx", tag), oe_ok, 1);
        bit_period(1'b1);
        check($sformatf("%s oe_release", tag), {cap_oe, cap_out}, 2'b01);
        if (v.rt != 2'd0) begin
            len = (v.rt == 2'd2) ? 136 : 48;
            for (int k = 1; k <= v.gap && n_done == done_before; k++) begin
                bit_period(1'b1);
                if (to_bit == 0 && cap_to) to_bit = k;
            end
            if (n_done == done_before) begin
                for (int i = len - 1; i >= 0; i--) bit_period(v.rsp[i]);
            end
            if (v.exp_to) check($sformatf("%s timeout_bit", tag), to_bit, RESP_TIMEOUT);
        end
        for (int k = 0; k < 20 && n_done == done_before; k++) clk_step(1'b0);
        check($sformatf("%s done_pulses", tag), n_done - done_before, 1);
        check($sformatf("%s timeout", tag), d_to, v.exp_to);
        check($sformatf("%s crc_err", tag), d_ce, v.exp_ce);
        check($sformatf("%s resp", tag), d_resp, v.exp_resp);
        check($sformatf("%s busy_with_done", tag), d_busy, 1);
        repeat (3) clk_step(1'b0);
        check($sformatf("%s idle_after", tag), {busy, done}, 2'b00);
        check($sformatf("%s status_hold", tag), {timeout, crc_err, resp}, {v.exp_to, v.exp_ce, v.exp_resp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [119:0] pay;
        logic [135:0] f;
        reset = 1'b1; start = 1'b0; bit_en = 1'b0; cmd_in = 1'b1;
        cmd_index = '0; cmd_arg = '0; resp_type = '0;
        repeat (3) @(negedge clk);
        check("rst busy_done", {busy, done}, 2'b00);
        check("rst status", {timeout, crc_err}, 2'b00);
        check("rst resp", resp, 0);
        check("rst cmd_line", {cmd_oe, cmd_out}, 2'b01);
        reset = 1'b0;
        clk_step(1'b0);

        pay = 120'h0123456789ABCDEF_FEDCBA98765432;
        vt[0] = mk(6'd0, 32'h0, 2'd0, '0, 0, -1, 48'h40_0000_0000_95, 1'b0, 1'b0, '0);
        vt[1] = mk(6'd8, 32'h1AA, 2'd1, 136'h08_0000_01AA_13, 5, -1,
                   48'h48_0000_01AA_87, 1'b0, 1'b0, 128'h8_0000_01AA);
        vt[2] = mk(6'd8, 32'h1AA, 2'd1, 136'h08_0000_01AA_13 ^ (136'd1 << 27), 5, 30,
                   48'h48_0000_01AA_87, 1'b0, 1'b1, 128'h8_0000_01AA ^ 128'h8_0000);
        vt[3] = mk(6'd55, 32'h0, 2'd1, '0, RESP_TIMEOUT + 4, -1,
                   48'h77_0000_0000_65, 1'b1, 1'b0, '0);
        vt[4] = mk(6'd8, 32'h1AA, 2'd1, 136'h08_0000_01AA_13, RESP_TIMEOUT - 1, 10,
                   48'h48_0000_01AA_87, 1'b0, 1'b0, 128'h8_0000_01AA);
        f = r2_frame(pay, 1'b1);
        vt[5] = mk(6'd2, 32'h0, 2'd2, f, 2, -1, tx_frame(6'd2, 32'h0), 1'b0, 1'b0, f[127:0]);
        f = r2_frame(pay, 1'b0);
        vt[6] = mk(6'd2, 32'h0, 2'd2, f, 2, -1, tx_frame(6'd2, 32'h0), 1'b0, 1'b1, f[127:0]);
        vt[7] = mk(6'd41, 32'h00FF_8000, 2'd3, {88'd0, 8'h3F, 32'h80FF_8000, 7'h7F, 1'b1}, 3, -1,
                   tx_frame(6'd41, 32'h00FF_8000), 1'b0, 1'b0, {90'd0, 6'h3F, 32'h80FF_8000});
        vt[8] = mk(6'd41, 32'h00FF_8000, 2'd3, {88'd0, 8'h3F, 32'h80FF_8000, 7'h7F, 1'b0}, 3, -1,
                   tx_frame(6'd41, 32'h00FF_8000), 1'b0, 1'b1, {90'd0, 6'h3F, 32'h80FF_8000});
        vt[9] = mk(6'd17, 32'hDEAD_BEEF, 2'd1, r1_frame(6'd17, 32'hDEAD_BEEF) ^ 136'h2, 1, -1,
                   tx_frame(6'd17, 32'hDEAD_BEEF), 1'b0, 1'b1, {90'd0, 6'd17, 32'hDEAD_BEEF});

        for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Reset during TX bit 20: immediate abort, no done afterwards.
        begin
            int done_before;
            cmd_index = 6'd8; cmd_arg = 32'h1AA; resp_type = 2'd1; start = 1'b1;
            clk_step(1'b0);
            start = 1'b0;
            for (int n = 0; n <= 20; n++) bit_period(1'b1);
            check("rst_mid tx_active", cap_oe, 1);
            #2 reset = 1'b1;
            #1;
            check("rst_mid busy_done", {busy, done}, 2'b00);
            check("rst_mid cmd_line", {cmd_oe, cmd_out}, 2'b01);
            check("rst_mid status", {timeout, crc_err, resp}, 130'd0);
            done_before = n_done;
            clk_step(1'b0);
            clk_step(1'b0);
            reset = 1'b0;
            for (int k = 0; k < 60; k++) bit_period(1'b1);
            check("rst_mid no_done", n_done - done_before, 0);
            check("rst_mid idle", {busy, cmd_oe}, 2'b00);
            run_vec(vt[1], "post_reset");
        end

        for (int t = 0; t < 24; t++) begin
            vec_t v;
            int   len, sel;
            v.idx  = 6'($urandom);
            v.arg  = $urandom;
            v.rt   = 2'($urandom_range(0, 3));
            if (v.rt == 2'd2) begin
                pay = {$urandom, $urandom, $urandom, 24'($urandom)};
                v.rsp = r2_frame(pay, 1'b1);
                len = 136;
            end else begin
                v.rsp = r1_frame(6'($urandom), $urandom);
                len = 48;
            end
            if ($urandom_range(0, 2) == 0) v.rsp[$urandom_range(0, len - 2)] ^= 1'b1;
            sel = $urandom_range(0, 9);
            v.gap = (sel == 0) ? RESP_TIMEOUT - 1 : (sel == 1) ? RESP_TIMEOUT + 1 : $urandom_range(0, 8);
            v.poke = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 47) : -1;
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
